// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, parity/length codes and length decode.
// Used by the transmitter and the baud counter shared with the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  function automatic logic [3:0] bits_count(input logic [1:0] code);
    logic [3:0] n;
    case (code)
      BITS_5:  n = 4'd5;
      BITS_6:  n = 4'd6;
      BITS_7:  n = 4'd7;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_baud_ctr.sv
// Bit-period counter: latches the divisor on restart and pulses tick on the last
// clock of every div+1 clock period while enabled.
module uart_baud_ctr #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] ctr_reg;
  logic [DIV_W-1:0] div_reg;

  // ctr never passes div_reg, so an all-ones divisor cannot wrap the counter
  assign tick = en && (ctr_reg == div_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_reg <= '0;
      div_reg <= '0;
    end else if (restart) begin
      ctr_reg <= '0;
      div_reg <= div;
    end else if (en) begin
      if (tick) begin
        ctr_reg <= '0;
      end else begin
        ctr_reg <= ctr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5-8 data bits, optional parity, 1/2 stop bits,
// runtime baud divisor, all latched per frame. Parity support needs UART_TX_PARITY_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             valid,
  output logic             ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  tx_state_t  state_reg, state_next;
  logic       tx_reg, tx_next;
  logic       done_reg, done_next;
  logic [7:0] data_reg, data_next;
  logic [3:0] nbits_reg, nbits_next;
  logic       stop_reg, stop_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic       stop_idx_reg, stop_idx_next;
  logic       transfer;
  logic       tick;
  logic       last_data_bit;

  assign ready    = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign tx       = tx_reg;
  assign done     = done_reg;
  assign transfer = valid && ready;

  assign last_data_bit = ({1'b0, bit_idx_reg} == (nbits_reg - 4'd1));

  uart_baud_ctr #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(transfer),
    .en     (busy),
    .div    (cfg_div),
    .tick   (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic       par_en_reg, par_en_next;
  logic       par_bit_reg, par_bit_next;
  logic [7:0] data_mask;
  logic [3:0] nbits_in;
  logic       par_en_in;
  logic       par_bit_in;

  assign nbits_in = bits_count(cfg_bits);

  // Parity only covers the data bits actually transmitted
  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign data_mask[gi] = (nbits_in > 4'(gi));
  end

  assign par_en_in  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
  assign par_bit_in = (^(data & data_mask)) ^ (cfg_parity == PAR_ODD);

  always_ff @(posedge clk) begin
    if (rst) begin
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
    end else begin
      par_en_reg  <= par_en_next;
      par_bit_reg <= par_bit_next;
    end
  end
`else
  logic unused_cfg_parity;
  assign unused_cfg_parity = ^cfg_parity;
`endif

  always_comb begin
    state_next    = state_reg;
    tx_next       = tx_reg;
    done_next     = 1'b0;
    data_next     = data_reg;
    nbits_next    = nbits_reg;
    stop_next     = stop_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
`ifdef UART_TX_PARITY_EN
    par_en_next   = par_en_reg;
    par_bit_next  = par_bit_reg;
`endif
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (transfer) begin
          data_next  = data;
          nbits_next = bits_count(cfg_bits);
          stop_next  = cfg_stop;
`ifdef UART_TX_PARITY_EN
          par_en_next  = par_en_in;
          par_bit_next = par_bit_in;
`endif
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          bit_idx_next = 3'd0;
          tx_next      = data_reg[0];
          state_next   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (last_data_bit) begin
            tx_next       = 1'b1;
            stop_idx_next = 1'b0;
            state_next    = STOP;
`ifdef UART_TX_PARITY_EN
            if (par_en_reg) begin
              tx_next    = par_bit_reg;
              state_next = PARITY;
            end
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = data_reg[bit_idx_reg + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tx_next       = 1'b1;
          stop_idx_next = 1'b0;
          state_next    = STOP;
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (tick) begin
          if (stop_idx_reg == stop_reg) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
      data_reg     <= 8'd0;
      nbits_reg    <= 4'd0;
      stop_reg     <= 1'b0;
      bit_idx_reg  <= 3'd0;
      stop_idx_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
      data_reg     <= data_next;
      nbits_reg    <= nbits_next;
      stop_reg     <= stop_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg; expectations follow UART_TX_PARITY_EN when defined.
module tb_uart_tx_cfg;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       data;
  logic             valid;
  logic             ready;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_bits;
  logic [1:0]       cfg_parity;
  logic             cfg_stop;
  logic             tx;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
    .cfg_div(cfg_div), .cfg_bits(cfg_bits), .cfg_parity(cfg_parity),
    .cfg_stop(cfg_stop), .tx(tx), .busy(busy), .done(done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one transfer and record tx per clock until done (done_at=-1 on timeout)
  task automatic run_frame(input logic [7:0] d, input logic [DIV_W-1:0] dv,
                           input logic [1:0] b, input logic [1:0] p, input logic s,
                           output int done_at, output logic [255:0] txs);
    done_at = -1;
    txs = '1;
    data = d; cfg_div = dv; cfg_bits = b; cfg_parity = p; cfg_stop = s; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int k = 0; k < 256; k++) begin
      txs[k] = tx;
      if (done) begin
        done_at = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic int first_bad(input logic [255:0] txs, input logic [15:0] ev,
                                   input int nframe, input int per);
    for (int k = 0; k < nframe * per; k++) begin
      if (txs[k] !== ev[k / per]) return k;
    end
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; data = 8'h00; cfg_div = '0;
    cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    $display("[TB] reset: tx=%b ready=%b busy=%b done=%b", tx, ready, busy, done);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_8n1;
    int da; int bad; logic [255:0] w;
    run_frame(8'h55, 4'd3, 2'b11, 2'b00, 1'b0, da, w);
    $display("[TB] 8n1 0x55 div=3: done_at=%0d", da);
    n_tests++; if (da !== 40) begin n_fail++; $display("FAIL 8n1_done_at: got %0d expected 40", da); end
    bad = first_bad(w, 16'b1010101010, 10, 4);
    n_tests++; if (bad != -1) begin n_fail++; $display("FAIL 8n1_wave: tx=%b at clock %0d", w[bad], bad); end
    n_tests++; if (ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL 8n1_end_flags: ready=%b busy=%b expected 1/0", ready, busy); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL 8n1_done_pulse: got %b expected 0 one clock later", done); end
  endtask

  task automatic test_parity_even_5b;
    int da; int bad; logic [255:0] w;
    run_frame(8'hE7, 4'd0, 2'b00, 2'b01, 1'b1, da, w);
    $display("[TB] 5E2 0xE7 div=0: done_at=%0d", da);
`ifdef UART_TX_PARITY_EN
    n_tests++; if (da !== 9) begin n_fail++; $display("FAIL even5_done_at: got %0d expected 9", da); end
    bad = first_bad(w, 16'b111001110, 9, 1);
`else
    n_tests++; if (da !== 8) begin n_fail++; $display("FAIL even5_done_at: got %0d expected 8", da); end
    bad = first_bad(w, 16'b11001110, 8, 1);
`endif
    n_tests++; if (bad != -1) begin n_fail++; $display("FAIL even5_wave: tx=%b at clock %0d", w[bad], bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_parity_odd_7b;
    int da; int bad; logic [255:0] w;
    run_frame(8'h00, 4'd1, 2'b10, 2'b10, 1'b0, da, w);
    $display("[TB] 7O1 0x00 div=1: done_at=%0d", da);
`ifdef UART_TX_PARITY_EN
    n_tests++; if (da !== 20) begin n_fail++; $display("FAIL odd7_done_at: got %0d expected 20", da); end
    bad = first_bad(w, 16'b1100000000, 10, 2);
`else
    n_tests++; if (da !== 18) begin n_fail++; $display("FAIL odd7_done_at: got %0d expected 18", da); end
    bad = first_bad(w, 16'b100000000, 9, 2);
`endif
    n_tests++; if (bad != -1) begin n_fail++; $display("FAIL odd7_wave: tx=%b at clock %0d", w[bad], bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_max_div;
    int da; int bad; logic [255:0] w;
    run_frame(8'h15, 4'hF, 2'b00, 2'b00, 1'b0, da, w);
    $display("[TB] 5N1 0x15 div=max: done_at=%0d", da);
    n_tests++; if (da !== 112) begin n_fail++; $display("FAIL maxdiv_done_at: got %0d expected 112", da); end
    bad = first_bad(w, 16'b1101010, 7, 16);
    n_tests++; if (bad != -1) begin n_fail++; $display("FAIL maxdiv_wave: tx=%b at clock %0d", w[bad], bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] ev1; logic [15:0] ev2; logic e;
    int bad; logic badv; int n_done; logic d20; logic d31; logic rdy20; logic busy21;
    ev1 = 16'b1101001010; ev2 = 16'b1001111000;
    bad = -1; badv = 1'b0; n_done = 0; d20 = 1'b0; d31 = 1'b0; rdy20 = 1'b0; busy21 = 1'b0;
    data = 8'hA5; cfg_div = 4'd1; cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    data = 8'h3C; cfg_div = 4'd0;
    for (int k = 0; k < 36; k++) begin
      if (k < 20) e = ev1[k / 2];
      else if (k == 20) e = 1'b1;
      else if (k <= 30) e = ev2[k - 21];
      else e = 1'b1;
      if (tx !== e && bad < 0) begin bad = k; badv = tx; end
      if (done === 1'b1) begin
        n_done++;
        if (k == 20) d20 = 1'b1;
        if (k == 31) d31 = 1'b1;
      end
      if (k == 20) rdy20 = ready;
      if (k == 21) begin busy21 = busy; valid = 1'b0; end
      @(posedge clk); #1;
    end
    $display("[TB] back_to_back 0xA5/0x3C: done pulses=%0d", n_done);
    n_tests++; if (bad != -1) begin n_fail++; $display("FAIL b2b_wave: tx=%b at clock %0d", badv, bad); end
    n_tests++; if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
    n_tests++; if (!(d20 && d31)) begin n_fail++; $display("FAIL b2b_done_time: at20=%b at31=%b expected 1/1", d20, d31); end
    n_tests++; if (!(rdy20 && busy21)) begin n_fail++; $display("FAIL b2b_handshake: ready@20=%b busy@21=%b expected 1/1", rdy20, busy21); end
  endtask

  task automatic test_reset_mid_frame;
    int da; int bad; logic [255:0] w; int glitches;
    data = 8'h00; cfg_div = 4'd1; cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b1 || tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre: busy=%b tx=%b expected 1/0", busy, tx); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("[TB] reset during data bit 3: tx=%b ready=%b busy=%b done=%b", tx, ready, busy, done);
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
    n_tests++; if (ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: ready=%b busy=%b expected 1/0", ready, busy); end
    glitches = 0;
    for (int k = 0; k < 30; k++) begin
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) glitches++;
      @(posedge clk); #1;
    end
    n_tests++; if (glitches !== 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d non-idle clocks expected 0", glitches); end
    run_frame(8'h0F, 4'd0, 2'b11, 2'b00, 1'b0, da, w);
    $display("[TB] frame after reset 0x0F: done_at=%0d", da);
    n_tests++; if (da !== 10) begin n_fail++; $display("FAIL rstmid_next_done: got %0d expected 10", da); end
    bad = first_bad(w, 16'b1000011110, 10, 1);
    n_tests++; if (bad != -1) begin n_fail++; $display("FAIL rstmid_next_wave: tx=%b at clock %0d", w[bad], bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_with_valid;
    rst = 1'b1; valid = 1'b1; data = 8'h00; cfg_div = 4'd2; cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL rstvalid_edge: busy=%b tx=%b expected 0/1", busy, tx); end
    rst = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    $display("[TB] rst with valid: busy=%b tx=%b ready=%b", busy, tx, ready);
    n_tests++; if (busy !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL rstvalid_after: busy=%b ready=%b expected 0/1", busy, ready); end
  endtask

  task automatic test_busy_ignore;
    logic [15:0] ev; int bad; logic badv; int da; logic rdy3; int extra;
    ev = 16'b1000011110; bad = -1; badv = 1'b0; da = -1; rdy3 = 1'b1; extra = 0;
    data = 8'h0F; cfg_div = 4'd0; cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 2) begin valid = 1'b1; data = 8'hF0; cfg_div = 4'd5; end
      if (k == 3) rdy3 = ready;
      if (k == 5) valid = 1'b0;
      if (k < 10 && tx !== ev[k] && bad < 0) begin bad = k; badv = tx; end
      if (done === 1'b1) begin da = k; break; end
      @(posedge clk); #1;
    end
    $display("[TB] valid while busy: done_at=%0d", da);
    n_tests++; if (da !== 10) begin n_fail++; $display("FAIL busyign_done_at: got %0d expected 10", da); end
    n_tests++; if (bad != -1) begin n_fail++; $display("FAIL busyign_wave: tx=%b at clock %0d", badv, bad); end
    n_tests++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL busyign_ready: got %b expected 0", rdy3); end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || tx !== 1'b1) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL busyign_no_second: %0d busy clocks expected 0", extra); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_even_5b();
    test_parity_odd_7b();
    test_max_div();
    test_back_to_back();
    test_reset_mid_frame();
    test_rst_with_valid();
    test_busy_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable 8N1-successor UART transmitter. It serialises one character per valid/ready transfer with runtime-selectable character length (5–8 bits), parity (none/even/odd), stop bits (1/2) and baud divisor, all latched per frame. It sits between a byte source (FIFO, command engine) and the board TX pin, replacing the fixed-format transmitter in new designs.

## Interface
Parameters:
- DIV_W, 16: width of baud divisor; bit period = div+1 clocks, so 1..2^DIV_W clocks.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- data  in  8  character, LSB first; bits above selected length ignored
- valid  in  1  source has a character; transfer occurs on a clk edge with valid && ready
- ready  out  1  block can accept a character
- cfg_div  in  DIV_W  bit period minus one, sampled at transfer
- cfg_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits, sampled at transfer
- cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none, sampled at transfer
- cfg_stop  in  1  0=one stop bit, 1=two, sampled at transfer
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress (state != IDLE)
- done  out  1  one-clock pulse when the last stop bit completes

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, ready=1. On transfer: latch data, div, bits, parity, stop; compute parity bit over the selected data bits only (even: XOR; odd: ~XOR); ready<=0, busy<=1, tx<=0, ctr<=0 -> START.
- Each non-IDLE state holds tx for exactly div+1 clocks: ctr counts 0..div; tick = (ctr == div_latched); on tick ctr<=0 and advance.
- START -> DATA with bit_idx=0, tx<=data[0].
- DATA: on tick, if bit_idx == nbits-1 -> PARITY (parity enabled) or STOP; else bit_idx+1, tx<=data[bit_idx+1].
- PARITY: tx=parity bit; on tick -> STOP.
- STOP: tx=1, stop_idx 0..cfg_stop; on tick with stop_idx == cfg_stop -> IDLE, done<=1 for one clock, ready<=1, busy<=0.
- Config inputs changing mid-frame have no effect on the current frame.
- valid while ready=0 is ignored; the source holds data/valid until transfer.

## Timing
- Reset values: tx=1, ready=1, busy=0, done=0; all counters 0; state IDLE.
- Transfer at edge N: tx=0 from edge N; frame length = (1 + nbits + p + nstop) × (div+1) clocks, p ∈ {0,1}.
- done and ready rise on the same edge that ends the last stop bit; the earliest next transfer is on the following edge, giving a 1-clock minimum idle gap.
- div=0: one clock per bit; all-ones div: 2^DIV_W clocks; ctr must not overflow.
- rst mid-frame: next edge tx=1, state IDLE, ready=1, no done pulse; latched character discarded.
- rst and valid asserted together: reset wins, no transfer.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state and cfg_parity decoding present as above.
- Undefined: cfg_parity ignored (treated as none), PARITY state and parity logic not generated; frame = start + data + stop.

## Structure
- Package uart_pkg: state enum (IDLE/START/DATA/PARITY/STOP), parity-mode constants (PAR_NONE/EVEN/ODD), bits-code constants, function mapping cfg_bits to data-bit count.
- One sub-module: uart_baud_ctr. It is a DIV_W counter with a restart input and latched divisor, and outputs tick; it is shared with the future receiver.

## Test plan
- div=3, 8 bits, no parity, 1 stop, data 0x55 -> tx 0,1,0,1,0,1,0,1,0,1 each 4 clocks; done at clock 40 after transfer.
- div=0, 5 bits, even parity, 2 stop, data 0xE7 (sent 00111) -> 1,1,1,0,0 then parity 1, stop 1,1; 9 clocks total; bits 7:5 not sent.
- odd parity, 7 bits, data 0x00 -> parity bit 1; with UART_TX_PARITY_EN undefined, the same stimulus gives no parity bit and a frame one bit shorter.
- Back-to-back: valid held with 0xA5 then 0x3C -> exactly one idle-high clock between frames; cfg_div changed mid-frame affects only the second frame.
- rst pulsed during DATA bit 3 -> tx=1 next clock, ready=1, no done; the following transfer sends a clean frame.
- valid while busy -> ignored; data change while ready=0 does not alter the frame in flight.
